// File: rtl/pi_error_filter64_water_pkg.sv
// Shared constants, state encoding and IEEE-754 double helpers for the water-path error filter.
package pi_error_filter64_water_pkg;

    localparam int unsigned EXTENDED_SINGLE = 64;
    localparam int unsigned ADD_LAT         = 7;
    localparam int unsigned MUL_LAT         = 5;
    localparam int unsigned LAT             = 3 * ADD_LAT + MUL_LAT;
    localparam int unsigned Y_DLY           = 2 * ADD_LAT + MUL_LAT;  // sta -> S3 result
    localparam int unsigned REF_DLY         = LAT - ADD_LAT;          // sta -> S4 operands
    localparam logic        ADD_SEL         = 1'b0;
    localparam logic        SUB_SEL         = 1'b1;
    localparam logic        ENA_MATH        = 1'b1;
    localparam logic [63:0] QNAN            = 64'h7FF8000000000000;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WAIT} state_t;

    function automatic logic fp_is_nan(input logic [63:0] a);
        return (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
    endfunction

    // Round, then pack; overflow goes to Inf, underflow flushes to signed zero.
    function automatic logic [63:0] fp_pack(input logic s, input logic signed [12:0] e,
                                            input logic [51:0] m, input logic rnd);
        logic [52:0]        mr;
        logic signed [12:0] er;
        mr = {1'b0, m} + 53'(rnd);
        er = e + $signed(13'(mr[52]));
        if (er >= 13'sd2047) return {s, 11'h7FF, 52'd0};
        if (er <= 13'sd0)    return {s, 63'd0};
        return {s, er[10:0], mr[51:0]};
    endfunction

    // Double multiply, round-to-nearest-even, denormals flushed.
    function automatic logic [63:0] fp_mul(input logic [63:0] a, input logic [63:0] b);
        logic               s;
        logic [105:0]       prod;
        logic signed [12:0] e;
        logic [51:0]        m;
        logic               g;
        logic               st;
        s = a[63] ^ b[63];
        if (fp_is_nan(a)) return a;
        if (fp_is_nan(b)) return b;
        if (a[62:52] == 11'h7FF || b[62:52] == 11'h7FF) begin
            if (a[62:52] == 11'd0 || b[62:52] == 11'd0) return QNAN;
            return {s, 11'h7FF, 52'd0};
        end
        if (a[62:52] == 11'd0 || b[62:52] == 11'd0) return {s, 63'd0};
        prod = 106'({1'b1, a[51:0]}) * 106'({1'b1, b[51:0]});
        e = $signed({2'b00, a[62:52]}) + $signed({2'b00, b[62:52]}) - 13'sd1023;
        if (prod[105]) begin
            m  = prod[104:53];
            g  = prod[52];
            st = |prod[51:0];
            e  = e + 13'sd1;
        end else begin
            m  = prod[103:52];
            g  = prod[51];
            st = |prod[50:0];
        end
        return fp_pack(s, e, m, g & (st | m[0]));
    endfunction

    // Double add, round-to-nearest-even, denormals flushed.
    function automatic logic [63:0] fp_add(input logic [63:0] a, input logic [63:0] b);
        logic [63:0]        x;
        logic [63:0]        y;
        logic [56:0]        mx;
        logic [56:0]        my;
        logic [56:0]        sh;
        logic [56:0]        sum;
        logic [10:0]        d;
        logic signed [12:0] e;
        logic               lost;
        if (fp_is_nan(a)) return a;
        if (fp_is_nan(b)) return b;
        if (a[62:52] == 11'h7FF) begin
            if (b[62:52] == 11'h7FF && a[63] != b[63]) return QNAN;
            return a;
        end
        if (b[62:52] == 11'h7FF) return b;
        if (a[62:52] == 11'd0) return (b[62:52] == 11'd0) ? {a[63] & b[63], 63'd0} : b;
        if (b[62:52] == 11'd0) return a;
        if (a[62:0] >= b[62:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        mx   = {2'b01, x[51:0], 3'b000};
        my   = {2'b01, y[51:0], 3'b000};
        d    = x[62:52] - y[62:52];
        lost = 1'b0;
        if (d > 11'd56) begin
            sh = 57'd1;
        end else begin
            sh    = my >> d;
            lost  = ((sh << d) != my);
            sh[0] = sh[0] | lost;
        end
        e = $signed({2'b00, x[62:52]});
        if (x[63] == y[63]) begin
            sum = mx + sh;
            if (sum[56]) begin
                sum = {1'b0, sum[56:2], sum[1] | sum[0]};
                e   = e + 13'sd1;
            end
        end else begin
            sum = mx - sh;
            if (sum == 57'd0) return 64'd0;
            for (int i = 0; i < 56; i++) begin
                if (!sum[55]) begin
                    sum = sum << 1;
                    e   = e - 13'sd1;
                end
            end
        end
        return fp_pack(x[63], e, sum[54:3], sum[2] & ((|sum[1:0]) | sum[3]));
    endfunction

    // Add or subtract b from a; a NaN operand passes through with its sign untouched.
    function automatic logic [63:0] fp_addsub(input logic [63:0] a, input logic [63:0] b,
                                              input logic sel);
        return fp_add(a, fp_is_nan(b) ? b : {b[63] ^ sel, b[62:0]});
    endfunction

endpackage

// File: rtl/pi_error_filter64_water_if.sv
// Step/result handshake between the error filter and its neighbours.
interface pi_error_filter64_water_if;
    import pi_error_filter64_water_pkg::*;

    logic                       i_rst_user;
    logic                       i_sta;
    logic [EXTENDED_SINGLE-1:0] i_meas;
    logic [EXTENDED_SINGLE-1:0] i_ref;
    logic [EXTENDED_SINGLE-1:0] o_x_err;
    logic                       o_done_read_x;
    logic                       o_sta_pi;
    logic                       o_busy;

    modport master (output i_rst_user, i_sta, i_meas, i_ref,
                    input  o_x_err, o_done_read_x, o_sta_pi, o_busy);
    modport slave  (input  i_rst_user, i_sta, i_meas, i_ref,
                    output o_x_err, o_done_read_x, o_sta_pi, o_busy);
endinterface

// File: rtl/pi_error_filter64_water_valid_delay_line.sv
// Fixed-depth shift register used to model core latency and to align side-band values.
module pi_error_filter64_water_valid_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_pipe [DEPTH];

    // Shift one stage per enabled cycle; synchronous clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) r_pipe[i] <= '0;
        end else if (i_en) begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < int'(DEPTH); i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[DEPTH-1];
endmodule

// File: rtl/pi_error_filter64_water.sv
// Trapezoidal low-pass of the plant signal and x_err = ref - y_filt for the water-path PI.
module pi_error_filter64_water
    import pi_error_filter64_water_pkg::*;
#(
    parameter logic [63:0] B0     = 64'h3FD0000000000000,
    parameter logic [63:0] A1     = 64'h3FE0000000000000,
    parameter logic [63:0] Y_INIT = 64'h0,
    parameter int unsigned LEAD   = 15
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    pi_error_filter64_water_if.slave  bus
);
    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic        r_sta_pi;
    logic [63:0] r_x_err;
    logic [63:0] r_y_prev;
    logic [63:0] r_u_prev;

    logic        w_accept;
    logic        w_tag_rst;
    logic [63:0] w_s;
    logic [63:0] w_p;
    logic [63:0] w_q_mul;
    logic [63:0] w_q;
    logic [63:0] w_y;
    logic [63:0] w_ref_al;
    logic [63:0] w_x_pre;
    logic [64:0] w_tag;

    assign w_accept  = bus.i_sta & ~r_busy & ~bus.i_rst_user;
    assign w_tag_rst = i_rst | bus.i_rst_user;

    // S1: s = u + u_prev, fed straight from the port so the whole chain fits LAT.
    pi_error_filter64_water_valid_delay_line #(.WIDTH(64), .DEPTH(ADD_LAT)) u_s1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(ENA_MATH),
        .i_d(fp_addsub(bus.i_meas, r_u_prev, ADD_SEL)), .o_q(w_s));

    // S2: p = B0*s.
    pi_error_filter64_water_valid_delay_line #(.WIDTH(64), .DEPTH(MUL_LAT)) u_s2p (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(ENA_MATH),
        .i_d(fp_mul(B0, w_s)), .o_q(w_p));

    // S2: q = A1*y_prev, issued alongside S1 and delayed to meet p.
    pi_error_filter64_water_valid_delay_line #(.WIDTH(64), .DEPTH(MUL_LAT)) u_s2q (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(ENA_MATH),
        .i_d(fp_mul(A1, r_y_prev)), .o_q(w_q_mul));

    pi_error_filter64_water_valid_delay_line #(.WIDTH(64), .DEPTH(ADD_LAT)) u_qal (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(ENA_MATH),
        .i_d(w_q_mul), .o_q(w_q));

    // S3: y = p + q.
    pi_error_filter64_water_valid_delay_line #(.WIDTH(64), .DEPTH(ADD_LAT)) u_s3 (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(ENA_MATH),
        .i_d(fp_addsub(w_p, w_q, ADD_SEL)), .o_q(w_y));

    // ref_held, aligned with the S4 operands.
    pi_error_filter64_water_valid_delay_line #(.WIDTH(64), .DEPTH(REF_DLY)) u_refal (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(ENA_MATH),
        .i_d(bus.i_ref), .o_q(w_ref_al));

    // Step tag carrying u[n]; cleared by rst_user so an aborted step never updates state.
    pi_error_filter64_water_valid_delay_line #(.WIDTH(65), .DEPTH(Y_DLY)) u_tag (
        .i_clk(i_clk), .i_rst(w_tag_rst), .i_en(ENA_MATH),
        .i_d({w_accept, bus.i_meas}), .o_q(w_tag));

    // S4: x = ref_held - y; r_x_err acts as the final stage of this core.
    pi_error_filter64_water_valid_delay_line #(.WIDTH(64), .DEPTH(ADD_LAT - 1)) u_s4 (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(ENA_MATH),
        .i_d(fp_addsub(w_ref_al, w_y, SUB_SEL)), .o_q(w_x_pre));

    // Filter state update at S3 completion.
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_rst_user) begin
            r_y_prev <= Y_INIT;
            r_u_prev <= 64'd0;
        end else if (w_tag[64]) begin
            r_y_prev <= w_y;
            r_u_prev <= w_tag[63:0];
        end
    end

    // Step control: RUN until the result lands, then WAIT out the lead to sta_pi.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 6'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sta_pi <= 1'b0;
            r_x_err  <= 64'd0;
        end else if (bus.i_rst_user) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 6'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sta_pi <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_sta_pi <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    if (w_accept) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_cnt   <= 6'd1;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'(LAT - 1)) begin
                        r_done  <= 1'b1;
                        r_x_err <= w_x_pre;
                        r_state <= ST_WAIT;
                        r_cnt   <= 6'd1;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'(LEAD)) begin
                        r_sta_pi <= 1'b1;
                        r_state  <= ST_IDLE;
                        r_cnt    <= 6'd0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_x_err       = r_x_err;
    assign bus.o_done_read_x = r_done;
    assign bus.o_sta_pi      = r_sta_pi;
    assign bus.o_busy        = r_busy;
endmodule

// File: tb/tb_pi_error_filter64_water.sv
// Directed bench for the water-path error filter: timing, filter values, abort and reset cases.
module tb_pi_error_filter64_water;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pi_error_filter64_water_if bus();

    pi_error_filter64_water dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] D_ONE  = 64'h3FF0000000000000;
    localparam logic [63:0] D_TWO  = 64'h4000000000000000;
    localparam logic [63:0] D_ZERO = 64'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse sta now (caller sits on a negedge) and watch 42 cycles; optional injections.
    task automatic run_step(input logic [63:0] m, input logic [63:0] r,
                            input int sta_at, input int rstu_at, input int rst_at,
                            output int n_done, output int done_at,
                            output int n_stapi, output int stapi_at, output int n_busy,
                            output logic [63:0] x_done, output logic [63:0] snap_x,
                            output logic [2:0] snap_ctl);
        n_done = 0; done_at = -1; n_stapi = 0; stapi_at = -1; n_busy = 0;
        x_done = '0; snap_x = '1; snap_ctl = '1;
        bus.i_meas     = m;
        bus.i_ref      = r;
        bus.i_sta      = 1'b1;
        bus.i_rst_user = (rstu_at == 0);
        for (int k = 1; k <= 42; k++) begin
            @(negedge clk);
            bus.i_sta      = 1'b0;
            bus.i_rst_user = 1'b0;
            rst            = 1'b0;
            if (bus.o_done_read_x) begin n_done++; done_at = k; x_done = bus.o_x_err; end
            if (bus.o_sta_pi) begin n_stapi++; stapi_at = k; end
            if (bus.o_busy) n_busy++;
            if (k == rst_at + 1) begin
                snap_x   = bus.o_x_err;
                snap_ctl = {bus.o_done_read_x, bus.o_sta_pi, bus.o_busy};
            end
            if (k == sta_at)  bus.i_sta      = 1'b1;
            if (k == rstu_at) bus.i_rst_user = 1'b1;
            if (k == rst_at)  rst            = 1'b1;
        end
    endtask

    int          nd, da, ns, sa, nb;
    logic [63:0] xd, sx;
    logic [2:0]  sc;

    // Ordinary step (optionally with a stray sta while busy) and its full set of checks.
    task automatic normal_step(input string name, input logic [63:0] m, input logic [63:0] r,
                               input int stray_sta, input logic [63:0] exp_x);
        run_step(m, r, stray_sta, -1, -1, nd, da, ns, sa, nb, xd, sx, sc);
        chk({name, "_done_at"},  64'(da), 64'd26);
        chk({name, "_stapi_at"}, 64'(sa), 64'd41);
        chk({name, "_n_done"},   64'(nd), 64'd1);
        chk({name, "_n_stapi"},  64'(ns), 64'd1);
        chk({name, "_n_busy"},   64'(nb), 64'd41);
        chk({name, "_x_done"},   xd, exp_x);
        chk({name, "_x_hold"},   bus.o_x_err, exp_x);
        chk({name, "_busy_end"}, 64'(bus.o_busy), 64'd0);
    endtask

    initial begin
        bus.i_sta      = 1'b0;
        bus.i_rst_user = 1'b0;
        bus.i_meas     = D_ZERO;
        bus.i_ref      = D_ZERO;
        rst            = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_x_err", bus.o_x_err, 64'd0);
        chk("rst_done",  64'(bus.o_done_read_x), 64'd0);
        chk("rst_stapi", 64'(bus.o_sta_pi), 64'd0);
        chk("rst_busy",  64'(bus.o_busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Three back-to-back steps at the minimum period, meas = 1.0, ref = 0.
        normal_step("step1", D_ONE, D_ZERO, -1, 64'hBFD0000000000000);
        normal_step("step2", D_ONE, D_ZERO, -1, 64'hBFE4000000000000);
        normal_step("step3", D_ONE, D_ZERO, -1, 64'hBFEA000000000000);

        // Stray sta at +10 is ignored: y = 0.5 + 0.5*0.8125 = 0.90625.
        normal_step("stray", D_ONE, D_ZERO, 10, 64'hBFED000000000000);

        // rst_user at +12 aborts the step; x_err keeps its value.
        run_step(D_ONE, D_ZERO, -1, 12, -1, nd, da, ns, sa, nb, xd, sx, sc);
        chk("abort_n_done",  64'(nd), 64'd0);
        chk("abort_n_stapi", 64'(ns), 64'd0);
        chk("abort_n_busy",  64'(nb), 64'd12);
        chk("abort_x_keep",  bus.o_x_err, 64'hBFED000000000000);

        normal_step("after_abort", D_ONE, D_ZERO, -1, 64'hBFD0000000000000);

        // sta together with rst_user: nothing starts, filter state cleared.
        run_step(D_ONE, D_ZERO, -1, 0, -1, nd, da, ns, sa, nb, xd, sx, sc);
        chk("collide_n_done",  64'(nd), 64'd0);
        chk("collide_n_stapi", 64'(ns), 64'd0);
        chk("collide_n_busy",  64'(nb), 64'd0);

        // Nonzero ref: y = 0.25, x = 0.75; then meas = 2.0: y = 0.875, x = 0.125.
        normal_step("ref1", D_ONE, D_ONE, -1, 64'h3FE8000000000000);
        normal_step("ref2", D_TWO, D_ONE, -1, 64'h3FC0000000000000);

        // rst in WAIT: y = 0.75 + 0.4375 = 1.1875 is presented, then everything clears.
        run_step(D_ONE, D_ZERO, -1, -1, 30, nd, da, ns, sa, nb, xd, sx, sc);
        chk("rstwait_n_done",  64'(nd), 64'd1);
        chk("rstwait_x_done",  xd, 64'hBFF3000000000000);
        chk("rstwait_n_stapi", 64'(ns), 64'd0);
        chk("rstwait_n_busy",  64'(nb), 64'd30);
        chk("rstwait_snap_x",  sx, 64'd0);
        chk("rstwait_snap_ctl", 64'(sc), 64'd0);

        normal_step("after_rst", D_ONE, D_ZERO, -1, 64'hBFD0000000000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
